spi_ram_responder: RTL and testbench
====================================

// Module: spi_ram_responder
// PURPOSE
//  SPI mode-0 responder emulating the byte-wide serial RAM that the SPI CPU drives
//  over its CS/MOSI/SCK/MISO pins. Decodes READ/WRITE commands, then streams data
//  out on MISO or stores bytes from MOSI, with an auto-incrementing address.
//  Used as the on-board/bench RAM model and as a standalone peripheral tile.
// PARAMETERS
//  ADDR_W     8     address bits; depth = 2**ADDR_W bytes; one address byte per command
//  SYNC_STG   2     synchronizer flops on cs_n/sck/mosi, minimum 2
// PORTS
//  clk          in   1   system clock; must run >= 8x SCK
//  rst          in   1   asynchronous, active-high reset
//  spi_cs_n     in   1   chip select, active low
//  spi_sck      in   1   serial clock, idle low (mode 0)
//  spi_mosi     in   1   serial data in, MSB first
//  spi_miso     out  1   serial data out, MSB first
//  spi_miso_oe  out  1   MISO drive enable; 1 only while streaming READ data
//  busy         out  1   1 whenever a transaction is in progress (state != IDLE)
//  wr_strobe    out  1   1-clk pulse when a byte is committed to memory
//  wr_addr      out  ADDR_W  address of the committed byte (valid with wr_strobe)
//  wr_data      out  8   committed byte (valid with wr_strobe)
//  bad_op       out  1   sticky: unknown opcode seen; cleared only by rst
// BEHAVIOUR
//  Reset: state=IDLE, spi_miso=0, spi_miso_oe=0, busy=0, wr_strobe=0, wr_addr=0,
//   wr_data=0, bad_op=0, bit counter=0, address register=0, all memory bytes=8'h00.
//  Inputs pass SYNC_STG flops; edges are detected on the synchronized sck/cs_n.
//   Input-to-action latency = SYNC_STG+1 clk.
//  Mode 0: MOSI is sampled on the detected SCK rise; MISO changes on the detected SCK fall.
//  States: IDLE -> CMD (cs_n fall) -> ADDR (8 bits) -> READ | WRITE | IGNORE.
//   CMD: shift 8 bits; 8'h03 -> ADDR(read), 8'h02 -> ADDR(write), any other -> IGNORE
//   and set bad_op.
//   ADDR: shift ADDR_W bits into the address register, then enter READ or WRITE.
//   READ: on the SCK fall after the last address bit, load mem[addr] into the TX shifter,
//   drive bit7, set oe=1, addr++. Each later fall shifts out the next bit. After 8 falls,
//   reload from the new addr and addr++.
//   WRITE: after 8 rises, commit mem[addr]=byte, pulse wr_strobe, addr++.
//   IGNORE: no response, oe=0, until cs_n rise.
//  Address increment wraps 2**ADDR_W-1 -> 0 in both READ and WRITE.
//  A cs_n rise (detected) in any state: return to IDLE in the same clk. oe=0, miso=0,
//   bit counter cleared, and a partial write byte is discarded (no commit, no strobe).
//  A cs_n rise and an SCK edge detected in the same clk: the cs_n rise wins and the
//   edge is ignored.
//  SCK edges while cs_n is high are ignored. A cs_n fall while SCK is high is a protocol
//   violation: the CMD count starts at the next rise.
//  Async rst mid-transaction: immediate return to the reset values above, memory
//   included. The next transaction needs a fresh cs_n fall.
// STRUCTURE
//  spi_ram_defs.vh (shared include): OP_READ=8'h03, OP_WRITE=8'h02, state encodings
//   S_IDLE/S_CMD/S_ADDR/S_READ/S_WRITE/S_IGNORE, STATE_W.
//  Sub-module spi_sync_edge: SYNC_STG-flop synchronizer plus rise/fall pulse outputs,
//   instantiated for sck and cs_n; mosi uses the plain synchronizer.
//  Top: FSM, 8-bit RX/TX shifters, 3-bit bit counter, address register, memory array.
// TESTING
//  Reset, then WRITE 02,10,A5,3C at sck=clk/8 -> wr_strobe twice: (10,A5) then (11,3C).
//  READ 03,10 + 16 clocks -> MISO returns A5 then 3C MSB-first; oe high only in data phase.
//  WRITE 02,FF,11,22 -> commits at FF then 00 (wrap). READ 03,FF -> 11, 22.
//  Opcode 8'h5A + 16 clocks -> bad_op=1, no wr_strobe, oe stays 0; next READ works normally.
//  WRITE 02,20, then 5 data bits and cs_n rise -> no strobe, mem[20] stays 00, busy=0
//   within SYNC_STG+2 clk.
//  Assert rst during READ data -> miso=0, oe=0, busy=0 at once; a following READ of the
//   address written earlier returns 00.

Source files
------------

// File: rtl/spi_ram_responder_pkg.sv
// Shared opcodes and FSM state encoding for the SPI RAM responder.
package spi_ram_responder_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam int         STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_READ,
        S_WRITE,
        S_IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_responder_if.sv
// SPI pins plus the write-commit and status sideband of the RAM responder.
interface spi_ram_responder_if #(
    parameter int ADDR_W = 8
);
    logic              spi_cs_n;
    logic              spi_sck;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              busy;
    logic              wr_strobe;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              bad_op;

    modport master (
        output spi_cs_n, spi_sck, spi_mosi,
        input  spi_miso, spi_miso_oe, busy,
        input  wr_strobe, wr_addr, wr_data, bad_op
    );

    modport slave (
        input  spi_cs_n, spi_sck, spi_mosi,
        output spi_miso, spi_miso_oe, busy,
        output wr_strobe, wr_addr, wr_data, bad_op
    );
endinterface

// File: rtl/spi_ram_responder_sync_edge.sv
// Multi-flop synchronizer with single-clk rise/fall pulses on the synced level.
module spi_ram_responder_sync_edge #(
    parameter int   STG     = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);
    logic [STG-1:0] r_sync;
    logic           r_prev;
    logic           w_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {STG{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STG-2:0], i_d};
            r_prev <= r_sync[STG-1];
        end
    end

    assign w_q    = r_sync[STG-1];
    assign o_rise = w_q & ~r_prev;
    assign o_fall = ~w_q & r_prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 byte-wide serial RAM: READ/WRITE commands, auto-increment address.
module spi_ram_responder
    import spi_ram_responder_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int SYNC_STG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_ram_responder_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic              w_sck_rise, w_sck_fall;
    logic              w_cs_rise, w_cs_fall;
    logic              w_mosi;
    logic [SYNC_STG-1:0] r_mosi_sync;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [7:0]        r_rx, w_rx_nxt, w_rx_shift;
    logic [7:0]        r_tx, w_tx_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt, w_addr_inc;
    logic              r_is_read, w_is_read_nxt;
    logic              r_oe, w_oe_nxt;
    logic              r_wr_strobe, w_wr_strobe_nxt;
    logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_nxt;
    logic [7:0]        r_wr_data, w_wr_data_nxt;
    logic              r_bad_op, w_bad_op_nxt;
    logic              w_we;
    logic [7:0]        r_mem [DEPTH];
    logic [7:0]        w_mem_rd;

    spi_ram_responder_sync_edge #(
        .STG     (SYNC_STG),
        .RST_VAL (1'b0)
    ) u_sck_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.spi_sck),
        .o_rise (w_sck_rise),
        .o_fall (w_sck_fall)
    );

    spi_ram_responder_sync_edge #(
        .STG     (SYNC_STG),
        .RST_VAL (1'b1)
    ) u_cs_sync (
        .clk    (clk),
        .rst    (rst),
        .i_d    (bus.spi_cs_n),
        .o_rise (w_cs_rise),
        .o_fall (w_cs_fall)
    );

    // MOSI shares the sck path depth so data lines up with the detected rise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mosi_sync <= '0;
        else     r_mosi_sync <= {r_mosi_sync[SYNC_STG-2:0], bus.spi_mosi};
    end

    assign w_mosi     = r_mosi_sync[SYNC_STG-1];
    assign w_cnt_inc  = r_cnt + 3'd1;
    assign w_rx_shift = {r_rx[6:0], w_mosi};
    assign w_addr_inc = r_addr + ADDR_W'(1);
    assign w_mem_rd   = r_mem[r_addr];

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rx_nxt        = r_rx;
        w_tx_nxt        = r_tx;
        w_addr_nxt      = r_addr;
        w_is_read_nxt   = r_is_read;
        w_oe_nxt        = r_oe;
        w_wr_strobe_nxt = 1'b0;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;
        w_bad_op_nxt    = r_bad_op;
        w_we            = 1'b0;

        // cs_n rise outranks any sck edge seen in the same clk
        if (w_cs_rise) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 3'd0;
            w_oe_nxt    = 1'b0;
            w_tx_nxt    = 8'h00;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        w_state_nxt = S_CMD;
                        w_cnt_nxt   = 3'd0;
                    end
                end
                S_CMD: begin
                    if (w_sck_rise) begin
                        w_rx_nxt  = w_rx_shift;
                        w_cnt_nxt = w_cnt_inc;
                        if (r_cnt == 3'd7) begin
                            unique case (1'b1)
                                (w_rx_shift == OP_READ): begin
                                    w_state_nxt   = S_ADDR;
                                    w_is_read_nxt = 1'b1;
                                end
                                (w_rx_shift == OP_WRITE): begin
                                    w_state_nxt   = S_ADDR;
                                    w_is_read_nxt = 1'b0;
                                end
                                default: begin
                                    w_state_nxt  = S_IGNORE;
                                    w_bad_op_nxt = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (w_sck_rise) begin
                        w_addr_nxt = ADDR_W'({r_addr, w_mosi});
                        w_cnt_nxt  = w_cnt_inc;
                        if (r_cnt == 3'(ADDR_W - 1)) begin
                            w_cnt_nxt   = 3'd0;
                            w_state_nxt = r_is_read ? S_READ : S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    if (w_sck_fall) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (r_cnt == 3'd0) begin
                            w_tx_nxt   = w_mem_rd;
                            w_oe_nxt   = 1'b1;
                            w_addr_nxt = w_addr_inc;
                        end else begin
                            w_tx_nxt = {r_tx[6:0], 1'b0};
                        end
                    end
                end
                S_WRITE: begin
                    if (w_sck_rise) begin
                        w_rx_nxt  = w_rx_shift;
                        w_cnt_nxt = w_cnt_inc;
                        if (r_cnt == 3'd7) begin
                            w_we            = 1'b1;
                            w_wr_strobe_nxt = 1'b1;
                            w_wr_addr_nxt   = r_addr;
                            w_wr_data_nxt   = w_rx_shift;
                            w_addr_nxt      = w_addr_inc;
                        end
                    end
                end
                S_IGNORE: begin
                    w_oe_nxt = 1'b0;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_rx        <= 8'h00;
            r_tx        <= 8'h00;
            r_addr      <= '0;
            r_is_read   <= 1'b0;
            r_oe        <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'h00;
            r_bad_op    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rx        <= w_rx_nxt;
            r_tx        <= w_tx_nxt;
            r_addr      <= w_addr_nxt;
            r_is_read   <= w_is_read_nxt;
            r_oe        <= w_oe_nxt;
            r_wr_strobe <= w_wr_strobe_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_bad_op    <= w_bad_op_nxt;
        end
    end

    // Memory is part of the reset domain: rst clears every byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 8'h00;
        end else if (w_we) begin
            r_mem[r_addr] <= w_rx_shift;
        end
    end

    assign bus.spi_miso    = r_tx[7];
    assign bus.spi_miso_oe = r_oe;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.wr_strobe   = r_wr_strobe;
    assign bus.wr_addr     = r_wr_addr;
    assign bus.wr_data     = r_wr_data;
    assign bus.bad_op      = r_bad_op;

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: SPI master tasks at sck = clk/8.
module tb_spi_ram_responder;

    localparam int ADDR_W   = 8;
    localparam int SYNC_STG = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] wq[$];

    spi_ram_responder_if #(.ADDR_W(ADDR_W)) bus ();

    spi_ram_responder #(
        .ADDR_W   (ADDR_W),
        .SYNC_STG (SYNC_STG)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.wr_strobe === 1'b1) wq.push_back({bus.wr_addr, bus.wr_data});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one bit per 80 ns; MISO sampled just before the sck rise
    task automatic xfer(input logic [7:0] tx, input int nbits,
                        output logic [7:0] rx, output logic oe_or,
                        output logic oe_and);
        rx = 8'h00;
        oe_or = 1'b0;
        oe_and = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = tx[7-i];
            #40;
            rx = {rx[6:0], bus.spi_miso};
            oe_or = oe_or | bus.spi_miso_oe;
            oe_and = oe_and & bus.spi_miso_oe;
            bus.spi_sck = 1'b1;
            #40;
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic run(input logic [7:0] op, input logic [7:0] adr,
                       input int nd, input logic [7:0] wd0,
                       input logic [7:0] wd1, output logic [7:0] rd0,
                       output logic [7:0] rd1, output logic oe_hdr,
                       output logic oe_any, output logic oe_all);
        logic [7:0] r;
        logic o1, a1;
        rd0 = 8'h00;
        rd1 = 8'h00;
        oe_any = 1'b0;
        oe_all = 1'b1;
        bus.spi_cs_n = 1'b0;
        #40;
        xfer(op, 8, r, oe_hdr, a1);
        xfer(adr, 8, r, o1, a1);
        oe_hdr = oe_hdr | o1;
        if (nd > 0) begin
            xfer(wd0, 8, rd0, o1, a1);
            oe_any = oe_any | o1;
            oe_all = oe_all & a1;
        end
        if (nd > 1) begin
            xfer(wd1, 8, rd1, o1, a1);
            oe_any = oe_any | o1;
            oe_all = oe_all & a1;
        end
        #40;
        bus.spi_cs_n = 1'b1;
        #80;
    endtask

    initial begin
        logic [7:0] d0, d1, r;
        logic oh, oa, ol, o1, a1;

        rst = 1'b1;
        bus.spi_cs_n = 1'b1;
        bus.spi_sck = 1'b0;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 32'(bus.spi_miso), 32'h0);
        check("rst_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_strobe", 32'(bus.wr_strobe), 32'h0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
        check("rst_wr_data", 32'(bus.wr_data), 32'h0);
        check("rst_bad_op", 32'(bus.bad_op), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        run(8'h02, 8'h10, 2, 8'hA5, 8'h3C, d0, d1, oh, oa, ol);
        check("wr_count", 32'(wq.size()), 32'd2);
        check("wr_0", (wq.size() > 0) ? 32'(wq[0]) : 32'hdead, 32'h10A5);
        check("wr_1", (wq.size() > 1) ? 32'(wq[1]) : 32'hdead, 32'h113C);
        check("wr_busy_end", 32'(bus.busy), 32'h0);
        check("wr_oe", 32'(oh | oa), 32'h0);
        wq.delete();

        run(8'h03, 8'h10, 2, 8'h00, 8'h00, d0, d1, oh, oa, ol);
        check("rd_byte0", 32'(d0), 32'hA5);
        check("rd_byte1", 32'(d1), 32'h3C);
        check("rd_oe_hdr", 32'(oh), 32'h0);
        check("rd_oe_data", 32'(ol), 32'h1);
        check("rd_oe_end", 32'(bus.spi_miso_oe), 32'h0);
        check("rd_no_strobe", 32'(wq.size()), 32'd0);

        run(8'h02, 8'hFF, 2, 8'h11, 8'h22, d0, d1, oh, oa, ol);
        check("wrap_wr_0", (wq.size() > 0) ? 32'(wq[0]) : 32'hdead, 32'hFF11);
        check("wrap_wr_1", (wq.size() > 1) ? 32'(wq[1]) : 32'hdead, 32'h0022);
        wq.delete();
        run(8'h03, 8'hFF, 2, 8'h00, 8'h00, d0, d1, oh, oa, ol);
        check("wrap_rd_0", 32'(d0), 32'h11);
        check("wrap_rd_1", 32'(d1), 32'h22);

        run(8'h5A, 8'h10, 1, 8'hFF, 8'h00, d0, d1, oh, oa, ol);
        check("bad_op_set", 32'(bus.bad_op), 32'h1);
        check("bad_no_strobe", 32'(wq.size()), 32'd0);
        check("bad_oe", 32'(oh | oa), 32'h0);
        run(8'h03, 8'h10, 1, 8'h00, 8'h00, d0, d1, oh, oa, ol);
        check("bad_next_rd", 32'(d0), 32'hA5);

        bus.spi_cs_n = 1'b0;
        #40;
        xfer(8'h02, 8, r, o1, a1);
        xfer(8'h20, 8, r, o1, a1);
        xfer(8'hFF, 5, r, o1, a1);
        bus.spi_cs_n = 1'b1;
        repeat (SYNC_STG + 2) @(negedge clk);
        check("part_busy", 32'(bus.busy), 32'h0);
        #80;
        check("part_no_strobe", 32'(wq.size()), 32'd0);
        run(8'h03, 8'h20, 1, 8'h00, 8'h00, d0, d1, oh, oa, ol);
        check("part_mem", 32'(d0), 32'h00);

        bus.spi_cs_n = 1'b0;
        #40;
        xfer(8'h03, 8, r, o1, a1);
        xfer(8'h10, 8, r, o1, a1);
        xfer(8'h00, 2, r, o1, a1);
        check("mid_bits", 32'(r[1:0]), 32'h2);
        #40;
        check("mid_oe", 32'(bus.spi_miso_oe), 32'h1);
        check("mid_miso", 32'(bus.spi_miso), 32'h1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_miso", 32'(bus.spi_miso), 32'h0);
        check("arst_oe", 32'(bus.spi_miso_oe), 32'h0);
        check("arst_busy", 32'(bus.busy), 32'h0);
        check("arst_bad_op", 32'(bus.bad_op), 32'h0);
        bus.spi_cs_n = 1'b1;
        bus.spi_sck = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        run(8'h03, 8'h10, 2, 8'h00, 8'h00, d0, d1, oh, oa, ol);
        check("arst_mem_0", 32'(d0), 32'h00);
        check("arst_mem_1", 32'(d1), 32'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
